// File: rtl/fifo_pkg.sv
// Shared encodings and helpers for the parametrised FIFO controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fifo_pkg;

  // Operation performed at the last clock edge, held in the state register.
  localparam logic [2:0] ST_INIT   = 3'b000;
  localparam logic [2:0] ST_NO_OP  = 3'b001;
  localparam logic [2:0] ST_WRITE  = 3'b010;
  localparam logic [2:0] ST_WR_ERR = 3'b011;
  localparam logic [2:0] ST_READ   = 3'b100;
  localparam logic [2:0] ST_RD_ERR = 3'b101;
  localparam logic [2:0] ST_RDWR   = 3'b110;
  localparam logic [2:0] ST_UNUSED = 3'b111;

  typedef enum logic [2:0] {
    S_INIT   = ST_INIT,
    S_NO_OP  = ST_NO_OP,
    S_WRITE  = ST_WRITE,
    S_WR_ERR = ST_WR_ERR,
    S_READ   = ST_READ,
    S_RD_ERR = ST_RD_ERR,
    S_RDWR   = ST_RDWR,
    S_UNUSED = ST_UNUSED   // never entered; decoded only for recovery
  } state_t;

  // Threshold test shared by the almost-full / almost-empty decodes.
  function automatic logic at_or_above(input int value, input int threshold);
    return value >= threshold;
  endfunction

endpackage

// File: rtl/fifo_mem_param.sv
// Storage array: synchronous write, registered read port with read enable.
// Latency: write visible next cycle; rd_data valid one cycle after rd_en.
// Backpressure: none; the controller only enables accepted operations.
module fifo_mem_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset; only written entries are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read; a same-address write in the same edge returns the old word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_ctrl_param.sv
// Parametrised synchronous FIFO: op-state FSM, pointers, occupancy, flags.
// Latency: 1 cycle from sampled request to d_out and ack/err pulses.
// Backpressure: writes rejected when full (unless paired with a read), reads rejected when empty.
module fifo_ctrl_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err
);

  localparam int                    DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] head, tail;
  logic                  do_wr, do_rd;
  logic                  wr_ack_nxt, wr_err_nxt, rd_ack_nxt, rd_err_nxt;

  // Flags decode the registered occupancy only.
  always_comb begin
    full         = (data_count == CNT_FULL);
    empty        = (data_count == '0);
    almost_full  = at_or_above(int'(data_count), AF_LEVEL);
    almost_empty = at_or_above(AE_LEVEL, int'(data_count));
  end

  // Decide which operations are accepted this edge and what the state records.
  always_comb begin
    do_wr      = 1'b0;
    do_rd      = 1'b0;
    wr_ack_nxt = 1'b0;
    wr_err_nxt = 1'b0;
    rd_ack_nxt = 1'b0;
    rd_err_nxt = 1'b0;
    state_nxt  = S_NO_OP;
    if (state != S_UNUSED) begin
      // A paired read frees a slot in the same edge, so full does not block it.
      do_rd      = rd_en && !empty;
      do_wr      = wr_en && (!full || do_rd);
      wr_ack_nxt = do_wr;
      wr_err_nxt = wr_en && !do_wr;
      rd_ack_nxt = do_rd;
      rd_err_nxt = rd_en && !do_rd;
      unique case ({wr_en, rd_en})
        2'b00:   state_nxt = S_NO_OP;
        2'b10:   state_nxt = do_wr ? S_WRITE : S_WR_ERR;
        2'b01:   state_nxt = do_rd ? S_READ  : S_RD_ERR;
        default: state_nxt = do_rd ? S_RDWR  : S_WRITE;
      endcase
    end
  end

  // State register, handshake pulses, pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_INIT;
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      state  <= state_nxt;
      wr_ack <= wr_ack_nxt;
      wr_err <= wr_err_nxt;
      rd_ack <= rd_ack_nxt;
      rd_err <= rd_err_nxt;
      if (do_wr) tail <= tail + PTR_ONE;
      if (do_rd) head <= head + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   data_count <= data_count + CNT_ONE;
        2'b01:   data_count <= data_count - CNT_ONE;
        default: data_count <= data_count;
      endcase
    end
  end

  fifo_mem_param #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (do_wr),
    .wr_addr (tail),
    .wr_data (d_in),
    .rd_en   (do_rd),
    .rd_addr (head),
    .rd_data (d_out)
  );

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Self-checking bench for fifo_ctrl_param: queue-based reference model plus scoreboard.
// Latency: expects responses one edge after each sampled request.
// Backpressure: exercises overflow, underflow and paired read+write at the limits.
module tb_fifo_ctrl_param;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en, rd_en;
  logic [31:0] d_in;
  logic [31:0] d_out;
  logic [4:0]  data_count;
  logic        full, empty, almost_full, almost_empty;
  logic        wr_ack, wr_err, rd_ack, rd_err;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        wa, we, ra, re;
    logic [31:0] dout;
    logic [4:0]  cnt;
    logic        f, e, af, ae;
  } obs_t;

  obs_t        exp_q[$];
  logic [31:0] model_q[$];
  logic [31:0] last_dout;

  fifo_ctrl_param #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (4),
    .AF_LEVEL   (14),
    .AE_LEVEL   (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .d_in         (d_in),
    .d_out        (d_out),
    .data_count   (data_count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .wr_ack       (wr_ack),
    .wr_err       (wr_err),
    .rd_ack       (rd_ack),
    .rd_err       (rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request and push the response the FIFO rules dictate.
  task automatic step(input logic w, input logic r, input logic [31:0] d);
    obs_t x;
    int   n;
    logic rok, wok;
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    d_in  = d;
    n   = model_q.size();
    rok = r && (n > 0);
    wok = w && ((n < 16) || rok);
    if (rok) last_dout = model_q.pop_front();
    if (wok) model_q.push_back(d);
    n      = model_q.size();
    x.wa   = wok;
    x.we   = w && !wok;
    x.ra   = rok;
    x.re   = r && !rok;
    x.dout = last_dout;
    x.cnt  = 5'(n);
    x.f    = (n == 16);
    x.e    = (n == 0);
    x.af   = (n >= 14);
    x.ae   = (n <= 2);
    exp_q.push_back(x);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_count"}, 64'(data_count), 64'd0);
    chk({tag, "_empty"}, 64'(empty), 64'd1);
    chk({tag, "_full"}, 64'(full), 64'd0);
    chk({tag, "_ae"}, 64'(almost_empty), 64'd1);
    chk({tag, "_af"}, 64'(almost_full), 64'd0);
    chk({tag, "_acks"}, 64'({wr_ack, wr_err, rd_ack, rd_err}), 64'd0);
    chk({tag, "_dout"}, 64'(d_out), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    model_q.delete();
    last_dout = '0;
    repeat (2) @(negedge clk);
    check_cleared(tag);
    chk({tag, "_state"}, 64'(3'(dut.state)), 64'd0);
    reset_n = 1'b1;
  endtask

  // Monitor: every edge that follows a request, compare DUT outputs to the oldest expectation.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{wa: wr_ack, we: wr_err, ra: rd_ack, re: rd_err, dout: d_out,
              cnt: data_count, f: full, e: empty, af: almost_full, ae: almost_empty};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t: got ack/err=%b%b%b%b dout=0x%0h cnt=%0d flags(f,e,af,ae)=%b%b%b%b expected ack/err=%b%b%b%b dout=0x%0h cnt=%0d flags=%b%b%b%b",
                   $time, a.wa, a.we, a.ra, a.re, a.dout, a.cnt, a.f, a.e, a.af, a.ae,
                   e.wa, e.we, e.ra, e.re, e.dout, e.cnt, e.f, e.e, e.af, e.ae);
        end
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    d_in      = '0;
    last_dout = '0;

    do_reset("reset");

    // Fill to full, then overflow.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 32'h100 + 32'(i));
    step(1'b1, 1'b0, 32'hDEAD);
    // Drain in order, then underflow.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    // Paired read+write at count 5, at full and at empty.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h200 + 32'(i));
    step(1'b1, 1'b1, 32'h2FF);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 32'h300 + 32'(i));
    step(1'b1, 1'b1, 32'h3FF);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 32'h0);
    step(1'b1, 1'b1, 32'h4AA);
    step(1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    // Wrap-around from a clean start.
    do_reset("wrap_reset");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h500 + 32'(i));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h600 + 32'(i));
    step(1'b0, 1'b0, 32'h0);
    chk("wrap_tail", 64'(dut.tail), 64'd4);
    chk("wrap_head", 64'(dut.head), 64'd10);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    // Asynchronous reset in the middle of a write burst at count 7.
    do_reset("burst_reset");
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 32'h700 + 32'(i));
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_cleared("async_reset");
    wr_en = 1'b0;
    model_q.delete();
    last_dout = '0;
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 1'b0, 32'hABCD);
    step(1'b0, 1'b0, 32'h0);
    chk("post_reset_tail", 64'(dut.tail), 64'd1);
    chk("post_reset_mem0", 64'(dut.u_mem.mem[0]), 64'hABCD);
    step(1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    // Random traffic: write-biased then read-biased to visit both limits.
    for (int i = 0; i < 400; i++) begin
      int wbias;
      wbias = (i < 200) ? 70 : 30;
      step(($urandom_range(0, 99) < wbias), ($urandom_range(0, 99) < (100 - wbias)), $urandom);
    end
    step(1'b0, 1'b0, 32'h0);

    // Let the scoreboard drain, bounded.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
